// File: rtl/lcd_timing_gen_pkg.sv
// Shared timing constants, FSM state type and frame-size helpers
// for the RGB LCD raster generator.
package lcd_timing_pkg;

  localparam int H_ACTIVE_D = 800;
  localparam int H_FP_D     = 40;
  localparam int H_SYNC_D   = 48;
  localparam int H_BP_D     = 40;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 13;
  localparam int V_SYNC_D   = 3;
  localparam int V_BP_D     = 29;
  localparam int X_W_D      = 11;
  localparam int Y_W_D      = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic int calc_ht(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int calc_vt(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Panel-side timing bundle: syncs, data enable, coordinates and
// line/frame start pulses.
interface lcd_timing_gen_if
  import lcd_timing_pkg::*;
#(
  parameter int X_W = X_W_D,
  parameter int Y_W = Y_W_D
);

  logic           LCD_HSYNC;
  logic           LCD_VSYNC;
  logic           LCD_DE;
  logic [X_W-1:0] PixelX;
  logic [Y_W-1:0] PixelY;
  logic           LineStart;
  logic           FrameStart;

  modport master (
    output LCD_HSYNC, LCD_VSYNC, LCD_DE,
    output PixelX, PixelY,
    output LineStart, FrameStart
  );

  modport slave (
    input LCD_HSYNC, LCD_VSYNC, LCD_DE,
    input PixelX, PixelY,
    input LineStart, FrameStart
  );

endinterface

// File: rtl/lcd_timing_gen_counter.sv
// Wrapping axis counter; count_d_o exposes the next value so the
// parent can register decodes aligned with the count itself.
module lcd_axis_counter #(
  parameter int TOTAL = 2,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         last_o
);

  localparam logic [W-1:0] MAX = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign last_o    = (count_q == MAX);
  assign count_o   = count_q;
  assign count_d_o = count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = last_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: start/stop only on frame boundaries,
// all outputs registered and aligned with PixelX/PixelY.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = 1'b0,
  parameter int   X_W      = X_W_D,
  parameter int   Y_W      = Y_W_D
) (
  input  logic              PixelClk,
  input  logic              RST,
  input  logic              EN,
  lcd_timing_gen_if.master  lcd
);

  localparam int HT = calc_ht(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = calc_vt(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [X_W-1:0] HA  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HSB = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HSE = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] VA  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VSB = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VSE = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  state_e state_q, state_d;

  logic           h_inc, v_inc;
  logic           h_last, v_last;
  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;

  logic act_d, de_d, hs_d, vs_d, ls_d, fs_d;
  logic de_q, hs_q, vs_q, ls_q, fs_q;

  assign h_inc = (state_q != IDLE);
  assign v_inc = h_inc && h_last;

  lcd_axis_counter #(.TOTAL(HT), .W(X_W)) u_h (
    .clk_i     (PixelClk),
    .clr_i     (RST),
    .inc_i     (h_inc),
    .count_o   (h_q),
    .count_d_o (h_d),
    .last_o    (h_last)
  );

  lcd_axis_counter #(.TOTAL(VT), .W(Y_W)) u_v (
    .clk_i     (PixelClk),
    .clr_i     (RST),
    .inc_i     (v_inc),
    .count_o   (v_q),
    .count_d_o (v_d),
    .last_o    (v_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (EN) state_d = RUN;
      RUN:     if (!EN) state_d = DRAIN;
      DRAIN: begin
        if (EN) state_d = RUN;
        else if (h_last && v_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RST) state_d = IDLE;
  end

  // Decode from next-cycle counters so registered outputs line up.
  always_comb begin
    act_d = (state_d != IDLE);
    de_d  = act_d && (h_d < HA) && (v_d < VA);
    hs_d  = (act_d && (h_d >= HSB) && (h_d < HSE)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (act_d && (v_d >= VSB) && (v_d < VSE)) ? SYNC_POL : ~SYNC_POL;
    ls_d  = act_d && (h_d == '0);
    fs_d  = ls_d && (v_d == '0);
  end

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      state_q <= IDLE;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign lcd.LCD_HSYNC  = hs_q;
  assign lcd.LCD_VSYNC  = vs_q;
  assign lcd.LCD_DE     = de_q;
  assign lcd.PixelX     = h_q;
  assign lcd.PixelY     = v_q;
  assign lcd.LineStart  = ls_q;
  assign lcd.FrameStart = fs_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench: small 14x7 raster, directed scenarios plus
// random EN/RST against a frame-position reference model.
module tb_lcd_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  lcd_timing_gen_if #(.X_W(4), .Y_W(3)) lcd ();

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .X_W(4), .Y_W(3)
  ) dut (
    .PixelClk (clk),
    .RST      (rst),
    .EN       (en),
    .lcd      (lcd)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: running flag, linear position in frame, stop-pending flag.
  bit m_act = 0;
  bit m_dr  = 0;
  int m_p   = 0;

  int cyc     = 0;
  int last_fs = -1;
  int de_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt, max_x, max_y;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr_stats();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    ls_cnt = 0; fs_cnt = 0; max_x = 0; max_y = 0;
  endtask

  task automatic step(bit e, bit r);
    int h, v;
    logic [11:0] ev, ov;
    @(negedge clk);
    en  = e;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_act = 0; m_p = 0; m_dr = 0;
    end else if (!m_act) begin
      m_act = e; m_p = 0; m_dr = 0;
    end else if (m_p == FT - 1 && m_dr && !e) begin
      m_act = 0; m_p = 0; m_dr = 0;
    end else begin
      m_p  = (m_p + 1) % FT;
      m_dr = !e;
    end
    cyc++;
    #1;
    h = m_p % HT;
    v = m_p / HT;
    ev = {!(m_act && h >= HA + HF && h < HA + HF + HS),
          !(m_act && v >= VA + VF && v < VA + VF + VS),
          m_act && h < HA && v < VA,
          m_act && h == 0,
          m_act && m_p == 0,
          4'(h), 3'(v)};
    ov = {lcd.LCD_HSYNC, lcd.LCD_VSYNC, lcd.LCD_DE,
          lcd.LineStart, lcd.FrameStart, lcd.PixelX, lcd.PixelY};
    check("cycle", 32'(ov), 32'(ev));
    if (lcd.LCD_DE) de_cnt++;
    if (!lcd.LCD_HSYNC) hs_cnt++;
    if (!lcd.LCD_VSYNC) vs_cnt++;
    if (lcd.LineStart) ls_cnt++;
    if (lcd.FrameStart) begin
      fs_cnt++;
      if (last_fs >= 0) check("fs_gap", 32'(cyc - last_fs), 32'(FT));
      last_fs = cyc;
    end
    if (!m_act) last_fs = -1;
    if (int'(lcd.PixelX) > max_x) max_x = int'(lcd.PixelX);
    if (int'(lcd.PixelY) > max_y) max_y = int'(lcd.PixelY);
  endtask

  task automatic run_to(int p, bit e);
    int n = 0;
    while (m_p != p && n < 3 * FT) begin
      step(e, 0);
      n++;
    end
    check("run_to", 32'(m_p), 32'(p));
  endtask

  task automatic drain_to_idle(output int n);
    n = 0;
    do begin
      step(0, 0);
      n++;
    end while (!(lcd.PixelX == 0 && lcd.PixelY == 0 && !lcd.LineStart)
               && n < 3 * FT);
  endtask

  initial begin
    int n;
    // 1: reset, then first frame
    step(0, 1);
    step(0, 1);
    check("rst_de", 32'(lcd.LCD_DE), 0);
    check("rst_hs", 32'(lcd.LCD_HSYNC), 1);
    check("rst_vs", 32'(lcd.LCD_VSYNC), 1);
    clr_stats();
    step(1, 0);
    check("first_fs", 32'(lcd.FrameStart), 1);
    check("first_de", 32'(lcd.LCD_DE), 1);
    check("first_xy", 32'({lcd.PixelX, lcd.PixelY}), 0);
    for (int i = 1; i < FT; i++) step(1, 0);
    check("de_cnt", 32'(de_cnt), 32'(HA * VA));
    check("hs_cnt", 32'(hs_cnt), 32'(HS * VT));
    check("vs_cnt", 32'(vs_cnt), 32'(VS * HT));

    // 2: three continuous frames
    clr_stats();
    for (int i = 0; i < 3 * FT; i++) step(1, 0);
    check("fs_cnt", 32'(fs_cnt), 3);
    check("ls_cnt", 32'(ls_cnt), 32'(3 * VT));
    check("max_x", 32'(max_x), 32'(HT - 1));
    check("max_y", 32'(max_y), 32'(VT - 1));

    // 3: stop mid-frame; frame completes then idles
    run_to(2 * HT + 3, 1);
    drain_to_idle(n);
    check("drain_len", 32'(n), 32'(FT - (2 * HT + 3)));
    check("idle_de", 32'(lcd.LCD_DE), 0);
    check("idle_sync", 32'({lcd.LCD_HSYNC, lcd.LCD_VSYNC}), 3);
    check("idle_fs", 32'(lcd.FrameStart), 0);

    // 4: drop at v=1, raise at v=4, frame uninterrupted
    step(1, 0);
    check("restart_fs", 32'(lcd.FrameStart), 1);
    run_to(HT, 1);
    run_to(4 * HT, 0);
    clr_stats();
    n = 0;
    while (fs_cnt == 0 && n < 2 * FT) begin
      step(1, 0);
      n++;
    end
    check("resume_fs", 32'(fs_cnt), 1);

    // 5: long idle, then start
    drain_to_idle(n);
    clr_stats();
    for (int i = 0; i < 20; i++) step(0, 0);
    check("idle_static", 32'(ls_cnt + de_cnt + max_x + max_y), 0);
    step(1, 0);
    check("start_fs", 32'(lcd.FrameStart), 1);
    check("start_x", 32'(lcd.PixelX), 0);

    // 6: reset mid-frame
    run_to(3 * HT + 5, 1);
    step(1, 1);
    check("mrst_de", 32'(lcd.LCD_DE), 0);
    check("mrst_xy", 32'({lcd.PixelX, lcd.PixelY}), 0);
    step(1, 0);
    check("mrst_fs", 32'(lcd.FrameStart), 1);

    // Random EN segments with occasional reset
    for (int s = 0; s < 40; s++) begin
      bit e;
      int len;
      e   = ($urandom % 3) != 0;
      len = $urandom_range(1, 150);
      for (int i = 0; i < len; i++) step(e, ($urandom % 300) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
